// File: rtl/xgriscv_lsu_pkg.sv
// Shared constants, state encoding and helper functions for the xgriscv load/store unit.
// Optional feature macro used by the top: XGRISCV_LSU_MISALIGNED_SPLIT_EN.
package xgriscv_lsu_pkg;

    localparam int XLEN = 32;

    // RV32I funct3 encodings for loads
    localparam logic [2:0] LSU_F3_LB  = 3'b000;
    localparam logic [2:0] LSU_F3_LH  = 3'b001;
    localparam logic [2:0] LSU_F3_LW  = 3'b010;
    localparam logic [2:0] LSU_F3_LBU = 3'b100;
    localparam logic [2:0] LSU_F3_LHU = 3'b101;

    // RV32I funct3 encodings for stores
    localparam logic [2:0] LSU_F3_SB  = 3'b000;
    localparam logic [2:0] LSU_F3_SH  = 3'b001;
    localparam logic [2:0] LSU_F3_SW  = 3'b010;

    // Byte-lane masks (bit i enables byte lane i of the memory word)
    localparam logic [3:0] AMP_NONE = 4'b0000;
    localparam logic [3:0] AMP_B0   = 4'b0001;
    localparam logic [3:0] AMP_B1   = 4'b0010;
    localparam logic [3:0] AMP_B2   = 4'b0100;
    localparam logic [3:0] AMP_B3   = 4'b1000;
    localparam logic [3:0] AMP_H0   = 4'b0011;
    localparam logic [3:0] AMP_H1   = 4'b1100;
    localparam logic [3:0] AMP_W    = 4'b1111;

    // LSU sequencing states (2-bit encoding)
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    // Legal funct3 codes: loads accept B/H/W/BU/HU, stores only B/H/W.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == LSU_F3_SB) || (f3 == LSU_F3_SH) || (f3 == LSU_F3_SW);
        end else begin
            ok = (f3 == LSU_F3_LB)  || (f3 == LSU_F3_LH) || (f3 == LSU_F3_LW) ||
                 (f3 == LSU_F3_LBU) || (f3 == LSU_F3_LHU);
        end
        return ok;
    endfunction

    // Halfword on an odd address or word not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a_lo[0];
            2'b10:   mis = (a_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-lane mask for an aligned access of the size encoded in f3[1:0].
    function automatic logic [3:0] amp_for(input logic [2:0] f3, input logic [1:0] a_lo);
        logic [3:0] amp;
        case (f3[1:0])
            2'b00: begin
                case (a_lo)
                    2'b00:   amp = AMP_B0;
                    2'b01:   amp = AMP_B1;
                    2'b10:   amp = AMP_B2;
                    default: amp = AMP_B3;
                endcase
            end
            2'b01:   amp = a_lo[1] ? AMP_H1 : AMP_H0;
            2'b10:   amp = AMP_W;
            default: amp = AMP_NONE;
        endcase
        return amp;
    endfunction

    // Sign/zero extension of right-justified load data.
    function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            LSU_F3_LB:  r = {{24{d[7]}}, d[7:0]};
            LSU_F3_LH:  r = {{16{d[15]}}, d[15:0]};
            LSU_F3_LW:  r = d;
            LSU_F3_LBU: r = {24'b0, d[7:0]};
            LSU_F3_LHU: r = {16'b0, d[15:0]};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xgriscv_lsu_align.sv
// Combinational byte-lane logic: lane mask from size/offset, and lane selection plus
// sign/zero extension of the memory read word.
module xgriscv_lsu_align
    import xgriscv_lsu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      amp_o,
    output logic [XLEN-1:0] ext_o
);

    logic [XLEN-1:0] lane;

    // Shift the addressed lane down to bit 0, then extend according to funct3
    always_comb begin
        amp_o = amp_for(funct3_i, addr_lo_i);
        lane  = rdata_i >> {addr_lo_i, 3'b000};
        ext_o = extend_load(funct3_i, lane);
    end

endmodule

// File: rtl/xgriscv_lsu.sv
// Load/store unit between the MEM stage and the data memory.
// Optional feature: define XGRISCV_LSU_MISALIGNED_SPLIT_EN to execute misaligned halfword/word
// accesses as ascending single-byte accesses; otherwise they complete with resp_err.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
// high only in IDLE, so the payload must stay stable while req_valid is high and req_ready low.
// resp_valid is a single-cycle pulse, with resp_err/resp_rdata valid in that same cycle.
module xgriscv_lsu
    import xgriscv_lsu_pkg::*;
#(
    parameter int XLEN_P   = 32,
    parameter int RESP_REG = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN_P-1:0] req_addr,
    input  logic [XLEN_P-1:0] req_wdata,
    output logic              resp_valid,
    output logic [XLEN_P-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [3:0]        mem_amp,
    output logic [XLEN_P-1:0] mem_a,
    output logic [XLEN_P-1:0] mem_wd,
    input  logic [XLEN_P-1:0] mem_rd,
    output logic [1:0]        dbg_state
);

`ifdef XGRISCV_LSU_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic              split_q, split_d;
    logic [XLEN_P-1:0] addr_q, addr_d;     // address of the current (byte) access
    logic [XLEN_P-1:0] wdata_q, wdata_d;   // store data, shifted down one byte per split step
    logic [1:0]        cnt_q, cnt_d;       // byte index within a split access
    logic [1:0]        last_q, last_d;     // index of the final byte of a split access
    logic [XLEN_P-1:0] asm_q, asm_d;       // little-endian assembly of split load bytes
    logic              err_q, err_d;
    logic [XLEN_P-1:0] rdata_q, rdata_d;

    logic              in_access;
    logic              req_mis;
    logic [2:0]        align_f3;
    logic [3:0]        align_amp;
    logic [XLEN_P-1:0] lane_ext;
    logic [XLEN_P-1:0] asm_full;

    // Split accesses are always byte-wide; otherwise use the request size
    assign align_f3 = split_q ? LSU_F3_LBU : f3_q;

    xgriscv_lsu_align u_align (
        .funct3_i  (align_f3),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (mem_rd),
        .amp_o     (align_amp),
        .ext_o     (lane_ext)
    );

    assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);

    // Next-state and datapath updates for IDLE -> ACCESS (xN) -> RESP -> IDLE
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        split_d  = split_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        asm_d    = asm_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        asm_full = asm_q;
        asm_full[{cnt_q, 3'b000} +: 8] = lane_ext[7:0];

        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    asm_d   = '0;
                    rdata_d = '0;
                    last_d  = (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
                    if (!f3_legal(req_we, req_funct3) || (req_mis && !SPLIT_EN)) begin
                        // Rejected requests skip the memory entirely
                        state_d = LSU_RESP;
                        err_d   = 1'b1;
                        split_d = 1'b0;
                    end else begin
                        state_d = LSU_ACCESS;
                        err_d   = 1'b0;
                        split_d = req_mis;
                    end
                end
            end
            LSU_ACCESS: begin
                if (!split_q) begin
                    state_d = LSU_RESP;
                    rdata_d = we_q ? '0 : lane_ext;
                end else begin
                    asm_d = asm_full;
                    if (cnt_q == last_q) begin
                        state_d = LSU_RESP;
                        rdata_d = we_q ? '0 : extend_load(f3_q, asm_full);
                    end else begin
                        // Plain increment carries across word and 32-bit boundaries
                        cnt_d   = cnt_q + 2'd1;
                        addr_d  = addr_q + 32'd1;
                        wdata_d = wdata_q >> 8;
                    end
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and request registers; async reset aborts any request in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            split_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            asm_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            split_q <= split_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs are decoded from registers only, so reset drops mem_we at once
    assign in_access  = (state_q == LSU_ACCESS);
    assign req_ready  = (state_q == LSU_IDLE);
    assign resp_valid = (state_q == LSU_RESP);
    assign resp_err   = resp_valid && err_q;
    assign mem_we     = in_access && we_q;
    assign mem_amp    = in_access ? align_amp : AMP_NONE;
    assign mem_a      = {addr_q[XLEN_P-1:2], 2'b00};
    assign mem_wd     = (in_access && we_q)
                      ? (split_q ? {{(XLEN_P-8){1'b0}}, wdata_q[7:0]} : wdata_q)
                      : '0;
    assign dbg_state  = state_q;

    generate
        if (RESP_REG == 1) begin : g_resp_reg
            assign resp_rdata = rdata_q;
        end else begin : g_resp_reserved
            // Reserved setting: keeps the registered path so the port stays defined
            assign resp_rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Testbench for xgriscv_lsu: byte-addressed memory behind the DUT, byte-level reference
// memory and request model, directed cases followed by randomized requests.
module tb_xgriscv_lsu;

`ifdef XGRISCV_LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [3:0]  mem_amp;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [1:0]  dbg_state;

  xgriscv_lsu dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_amp    (mem_amp),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .dbg_state  (dbg_state)
  );

  // ---------------- memory seen by the DUT ----------------
  logic [7:0] dmem    [0:4095];
  logic [7:0] ref_mem [0:4095];

  assign mem_rd = {dmem[{mem_a[11:2], 2'd3}], dmem[{mem_a[11:2], 2'd2}],
                   dmem[{mem_a[11:2], 2'd1}], dmem[{mem_a[11:2], 2'd0}]};

  // write data is unshifted: enabled lanes take consecutive bytes from mem_wd[7:0] upward
  function automatic int lane_src(input logic [3:0] amp, input int l);
    int s = 0;
    for (int i = 0; i < l; i++) if (amp[i]) s++;
    return s;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_amp[l]) dmem[{mem_a[11:2], l[1:0]}] <= mem_wd[8*lane_src(mem_amp, l) +: 8];
      end
    end
  end

  // ---------------- counters / monitors ----------------
  int  n_vec = 0, n_err = 0;
  int  n_hs = 0, n_resp = 0, exp_hs = 0, exp_resp = 0;
  time last_hs_t = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) if (rstn && req_valid && req_ready) n_hs++;
  always @(negedge clk) if (resp_valid) n_resp++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  // little-endian read of n bytes, then arithmetic sign extension for LB/LH
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n = size_of(f3);
    longint v = 0;
    for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[(a + k) & 32'hFFF]) << (8*k));
    if (f3[2] == 1'b0 && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] byte_mask(input int n);
    longint m = (longint'(1) << (8*n)) - 1;
    return m[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit keep);
    int n, lat, nacc, got_acc;
    bit ok, mis, err, got;
    logic [31:0] ak, amp_e;
    n    = size_of(f3);
    ok   = legal(we, f3);
    mis  = (a % 32'(n)) != 0;
    err  = !ok || (mis && !SPLIT);
    nacc = err ? 0 : (mis ? n : 1);
    lat  = err ? 1 : (mis ? 1 + n : 2);
    exp_q.push_back((err || we) ? 32'h0 : ref_load(f3, a));

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    for (int w = 0; w < 8 && !req_ready; w++) @(negedge clk);
    check("req_ready", req_ready, 1);
    @(posedge clk);
    last_hs_t = $time;
    exp_hs++;
    got = 0; got_acc = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
      if (mem_amp != 4'b0 || mem_we) begin
        ak    = mis ? a + got_acc : a;
        amp_e = mis ? (32'd1 << (ak & 32'd3)) : (((32'd1 << n) - 1) << (a & 32'd3));
        check("acc_addr", mem_a, ak & ~32'h3);
        check("acc_amp", mem_amp, amp_e);
        check("acc_we", mem_we, we);
        if (we) begin
          if (mis) check("acc_wd_byte", mem_wd & 32'hFF, (d >> (8*got_acc)) & 32'hFF);
          else     check("acc_wd", mem_wd & byte_mask(n), d & byte_mask(n));
        end
        got_acc++;
      end
      if (resp_valid) begin
        got = 1;
        exp_resp++;
        check("latency", c, lat);
        check("resp_err", resp_err, err);
        check("resp_rdata", resp_rdata, exp_q.pop_front());
        check("ready_in_resp", req_ready, 0);
      end
    end
    if (!got) begin
      check("resp_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    check("n_access", got_acc, nacc);
    if (we && !err) for (int k = 0; k < n; k++) ref_mem[(a + k) & 32'hFFF] = d[8*k +: 8];
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  ld_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [31:0] ab, db;
  int          kill;
  int          r0;
  time         t0;

  initial begin
    for (int i = 0; i < 4096; i++) begin dmem[i] = 8'h00; ref_mem[i] = 8'h00; end

    // reset state
    repeat (2) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_amp", mem_amp, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wd", mem_wd, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    // aligned store, byte store into zeroed word, load extension cases
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    do_req(1'b1, 3'b010, 32'h10, 32'h0, 1'b0);
    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    do_req(1'b1, 3'b010, 32'h10, 32'h80FF1234, 1'b0);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);

    // misaligned word across a word boundary
    for (int k = 0; k < 4; k++) do_req(1'b1, 3'b000, 32'h21 + k, 32'h11 * (k + 1), 1'b0);
    do_req(1'b0, 3'b010, 32'h21, 32'h0, 1'b0);
    do_req(1'b0, 3'b001, 32'h23, 32'h0, 1'b0);

    // illegal funct3 for a store
    do_req(1'b1, 3'b100, 32'h40, 32'h12345678, 1'b0);

    // reset in the middle of a store: nothing further issued for it
    ab   = SPLIT ? 32'h22 : 32'h30;
    kill = SPLIT ? 2 : 1;
    db   = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = ab; req_wdata = db;
    check("abort_ready", req_ready, 1);
    @(posedge clk);
    exp_hs++;
    for (int c = 1; c <= kill; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("abort_we_before", mem_we, 1);
    r0 = n_resp;
    rstn = 1'b0;
    #1;
    check("abort_we_drop", mem_we, 0);
    check("abort_amp_drop", mem_amp, 0);
    check("abort_state", dbg_state, 0);
    if (SPLIT) for (int k = 0; k < kill - 1; k++) ref_mem[(ab + k) & 32'hFFF] = db[8*k +: 8];
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_resp", n_resp, r0);
    do_req(1'b0, 3'b010, ab & ~32'h3, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, (ab & ~32'h3) + 32'h4, 32'h0, 1'b0);

    // back-to-back loads with req_valid held, then an illegal load
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    t0 = last_hs_t;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    check("b2b_gap1", 32'((last_hs_t - t0) / 10), 3);
    t0 = last_hs_t;
    do_req(1'b0, 3'b010, 32'h24, 32'h0, 1'b1);
    check("b2b_gap2", 32'((last_hs_t - t0) / 10), 3);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);

    // 32-bit address wrap on a misaligned word
    do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b0);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b0);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);

    // randomized requests
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = we ? 3'($urandom_range(0, 2)) : ld_tab[$urandom_range(0, 4)];
      else                          f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
      else                           a = 32'h40 + $urandom_range(0, 63);
      do_req(we, f3, a, $urandom, 1'($urandom_range(0, 1)));
      req_valid = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("hs_count", n_hs, exp_hs);
    check("resp_count", n_resp, exp_resp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
